// File: rtl/bob_ctrl_pkg.sv
// Shared definitions for the branch ordering buffer recovery controller.
// Holds the controller state encoding, the speculative-state field widths
// and the packed layout of one BOB entry as presented at the buffer head.
package bob_ctrl_pkg;

    localparam int PC_W    = 64;
    localparam int BHR_W   = 12;
    localparam int LHIST_W = 10;
    localparam int RASP_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECOVER = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // Field order mirrors the BOB storage layout.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic               ch_we;
        logic               ch_dir;
        logic               brdir;
        logic [LHIST_W-1:0] lochist;
        logic [BHR_W-1:0]   bhr;
        logic [RASP_W-1:0]  rasptr;
    } bob_entry_t;

endpackage

// File: rtl/bob_perf_cnt.sv
// 32-bit wrapping event counter used for performance statistics.
// Ports: clock, reset_n (async active-low), inc (count enable),
//        count (current value, wraps from all-ones to zero).
module bob_perf_cnt (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= 32'd0;
        end else if (inc) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/bob_recovery_ctrl.sv
// Branch resolution / misprediction recovery controller for the 16-entry BOB.
// Accepts in-order resolutions from execute, pops the BOB head, emits a
// predictor-update pulse, and on a misprediction flushes the BOB, redirects
// fetch, restores speculative history / RAS pointer and stalls fetch.
// Ports:
//   br_*      : resolution handshake and actual outcome from execute
//   bob_*_i   : head entry of the BOB; bob_re_o pops it, bob_flush_o clears it
//   upd_*     : predictor update (one-cycle pulse per resolved branch)
//   redirect_*, restore_*, fetch_stall_o : recovery towards the front end
//   orphan_o  : a resolution arrived while the BOB was empty
//   *_cnt_o   : wrapping performance counters
module bob_recovery_ctrl
    import bob_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int INSN_BYTES   = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               br_valid_i,
    output logic               br_ready_o,
    input  logic               br_taken_i,
    input  logic [PC_W-1:0]    br_target_i,
    input  logic               bob_valid_i,
    input  logic [PC_W-1:0]    bob_pc_i,
    input  logic               bob_brdir_i,
    input  logic               bob_ch_we_i,
    input  logic               bob_ch_dir_i,
    input  logic [LHIST_W-1:0] bob_lochist_i,
    input  logic [BHR_W-1:0]   bob_bhr_i,
    input  logic [RASP_W-1:0]  bob_rasptr_i,
    output logic               bob_re_o,
    output logic               bob_flush_o,
    output logic               upd_valid_o,
    output logic [PC_W-1:0]    upd_pc_o,
    output logic               upd_taken_o,
    output logic [LHIST_W-1:0] upd_lochist_o,
    output logic [BHR_W-1:0]   upd_bhr_o,
    output logic               upd_ch_we_o,
    output logic               upd_ch_dir_o,
    output logic               redirect_valid_o,
    output logic [PC_W-1:0]    redirect_pc_o,
    output logic [BHR_W-1:0]   restore_bhr_o,
    output logic [LHIST_W-1:0] restore_lochist_o,
    output logic [RASP_W-1:0]  restore_rasptr_o,
    output logic               fetch_stall_o,
    output logic               orphan_o,
    output logic [31:0]        resolved_cnt_o,
    output logic [31:0]        mispred_cnt_o
);

    // Drain counter is loaded with FLUSH_CYCLES-1 and counts down to zero,
    // giving exactly FLUSH_CYCLES stall cycles in DRAIN.
    localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [3:0] drain_cnt;
    bob_entry_t head;
    logic       accept;
    logic       resolve;
    logic       mispredict;

    assign head = {bob_pc_i, bob_ch_we_i, bob_ch_dir_i, bob_brdir_i,
                   bob_lochist_i, bob_bhr_i, bob_rasptr_i};

    // Ready is masked by reset so every output reads 0 while reset is held.
    assign br_ready_o = reset_n && (state == ST_IDLE);
    assign accept     = br_valid_i && br_ready_o;
    assign resolve    = accept && bob_valid_i;
    assign mispredict = resolve && (br_taken_i != head.brdir);
    assign bob_re_o   = resolve;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            drain_cnt         <= 4'd0;
            bob_flush_o       <= 1'b0;
            upd_valid_o       <= 1'b0;
            upd_pc_o          <= '0;
            upd_taken_o       <= 1'b0;
            upd_lochist_o     <= '0;
            upd_bhr_o         <= '0;
            upd_ch_we_o       <= 1'b0;
            upd_ch_dir_o      <= 1'b0;
            redirect_valid_o  <= 1'b0;
            redirect_pc_o     <= '0;
            restore_bhr_o     <= '0;
            restore_lochist_o <= '0;
            restore_rasptr_o  <= '0;
            fetch_stall_o     <= 1'b0;
            orphan_o          <= 1'b0;
        end else begin
            upd_valid_o      <= 1'b0;
            redirect_valid_o <= 1'b0;
            bob_flush_o      <= 1'b0;
            orphan_o         <= 1'b0;
            fetch_stall_o    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && !bob_valid_i) begin
                        orphan_o <= 1'b1;
                    end
                    if (resolve) begin
                        upd_valid_o   <= 1'b1;
                        upd_pc_o      <= head.pc;
                        upd_taken_o   <= br_taken_i;
                        upd_lochist_o <= head.lochist;
                        upd_bhr_o     <= head.bhr;
                        upd_ch_we_o   <= head.ch_we;
                        upd_ch_dir_o  <= head.ch_dir;
                    end
                    // Recovery outputs are registered on the accept edge so
                    // they are valid during the single RECOVER cycle.
                    if (mispredict) begin
                        state             <= ST_RECOVER;
                        redirect_valid_o  <= 1'b1;
                        bob_flush_o       <= 1'b1;
                        fetch_stall_o     <= 1'b1;
                        redirect_pc_o     <= br_taken_i ? br_target_i
                                                        : head.pc + 64'(INSN_BYTES);
                        restore_bhr_o     <= {head.bhr[BHR_W-2:0], br_taken_i};
                        restore_lochist_o <= {head.lochist[LHIST_W-2:0], br_taken_i};
                        restore_rasptr_o  <= head.rasptr;
                    end
                end
                ST_RECOVER: begin
                    if (FLUSH_CYCLES > 0) begin
                        state         <= ST_DRAIN;
                        drain_cnt     <= DRAIN_LOAD;
                        fetch_stall_o <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        drain_cnt     <= drain_cnt - 4'd1;
                        fetch_stall_o <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    bob_perf_cnt u_resolved_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (resolve),
        .count   (resolved_cnt_o)
    );

    bob_perf_cnt u_mispred_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (mispredict),
        .count   (mispred_cnt_o)
    );

endmodule
